// File: rtl/serial_adder_driver.sv
// serial_adder_driver: feeds a W-bit operand pair LSB-first to an external
// bit-serial adder. It collects the returned sum bits into a parallel result.
// One extra flush cycle captures the carry-out and returns the adder carry to 0.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE and
// stays high with out_sum/out_carry stable until out_ready is seen.
module serial_adder_driver #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         ser_a,
    output logic         ser_b,
    input  logic         ser_sum,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_carry,
    output logic [1:0]   state_o
);

    localparam int CW = $clog2(W + 1);
    // Counter value of the flush cycle that follows the last data bit.
    localparam logic [CW-1:0] FLUSH = CW'(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_a_q, sh_a_d;
    logic [W-1:0]  sh_b_q, sh_b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;

    // State, counter, operand and result registers; reset abandons any operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Next-state and handshake decode. The operand registers shift in zeros.
    // After W shifts they are empty, so the serial outputs read 0 in the flush
    // cycle and in every cycle outside SHIFT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sh_a_d  = in_a;
                    sh_b_d  = in_b;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == FLUSH) begin
                    carry_d = ser_sum;
                    state_d = DONE;
                end else begin
                    // Bit k enters at the top. After W cycles it sits at position k.
                    sum_d  = {ser_sum, sum_q[W-1:1]};
                    sh_a_d = {1'b0, sh_a_q[W-1:1]};
                    sh_b_d = {1'b0, sh_b_q[W-1:1]};
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Serial bits come straight from flop outputs, so they cannot glitch.
    assign ser_a     = sh_a_q[0];
    assign ser_b     = sh_b_q[0];
    assign out_sum   = sum_q;
    assign out_carry = carry_q;
    assign state_o   = state_q;

endmodule
